// File: rtl/cpu_pkg.sv
// Shared encodings and helpers for the operand-fetch stage feeding the 16-bit ALU.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned IDX_W  = $clog2(NREGS);
  localparam int unsigned IMM_W  = 5;
  localparam int unsigned SH_W   = 2;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RD_A = 2'd1;
  localparam logic [ST_W-1:0] ST_RD_B = 2'd2;
  localparam logic [ST_W-1:0] ST_OUT  = 2'd3;

  localparam logic [SH_W-1:0] SH_NONE = 2'b00;
  localparam logic [SH_W-1:0] SH_LSL1 = 2'b01;
  localparam logic [SH_W-1:0] SH_LSR1 = 2'b10;
  localparam logic [SH_W-1:0] SH_ASR1 = 2'b11;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN = 2'b11;

  // Request fields captured at acceptance (op is held separately as ALUop).
  typedef struct packed {
    logic [IDX_W-1:0] rn;
    logic [IDX_W-1:0] rm;
    logic [SH_W-1:0]  shift;
    logic [IMM_W-1:0] imm5;
    logic             bsel;
    logic             asel;
  } req_t;

  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] v,
                                                input logic [SH_W-1:0]   sh);
    logic [DATA_W-1:0] r;
    r = v;
    case (sh)
      SH_LSL1: r = {v[DATA_W-2:0], 1'b0};
      SH_LSR1: r = {1'b0, v[DATA_W-1:1]};
      SH_ASR1: r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/regfile.sv
// 8x16 register file: one combinational read port with write-through bypass, one write port.
module regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_num,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_num] <= wr_data;
    end
  end

  // Same-cycle write to the index being read is forwarded so the latch sees new data.
  always_comb begin
    rd_data_c = mem[rd_num];
    if (wr_en && (wr_num == rd_num)) rd_data_c = wr_data;
  end

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: reads A then B through one regfile port and holds them for the ALU.
module operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  rn,
  input  logic [IDX_W-1:0]  rm,
  input  logic [SH_W-1:0]   shift,
  input  logic [IMM_W-1:0]  imm5,
  input  logic              bsel,
  input  logic              asel,
  input  logic [OP_W-1:0]   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic [OP_W-1:0]   ALUop
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_next;
  req_t              req_q;
  logic [IDX_W-1:0]  rd_num_c;
  logic [DATA_W-1:0] rd_data_c;

  assign rd_num_c = (state == ST_RD_A) ? req_q.rn : req_q.rm;

  regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_num    (wr_num),
    .wr_data   (wr_data),
    .rd_num    (rd_num_c),
    .rd_data_c (rd_data_c)
  );

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == ST_IDLE);
      out_valid <= (state_next == ST_OUT);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = ST_RD_A;
      ST_RD_A: state_next = ST_RD_B;
      ST_RD_B: state_next = ST_OUT;
      ST_OUT:  if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request snapshot and A/B/op latches; Ain/Bin are never touched while in OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
      Ain   <= '0;
      Bin   <= '0;
      ALUop <= OP_ADD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= '{rn: rn, rm: rm, shift: shift, imm5: imm5, bsel: bsel, asel: asel};
            ALUop <= op;
          end
        end
        ST_RD_A: Ain <= req_q.asel ? '0 : rd_data_c;
        ST_RD_B: Bin <= req_q.bsel ? sext_imm(req_q.imm5) : shift_b(rd_data_c, req_q.shift);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed table, hand-written reset abort, random transactions vs a model.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_num;
  logic [15:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  rn, rm;
  logic [1:0]  shift;
  logic [4:0]  imm5;
  logic        bsel, asel;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Ain, Bin;
  logic [1:0]  ALUop;

  int n_vec = 0;
  int n_mis = 0;

  operand_stage dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .rn(rn), .rm(rm), .shift(shift),
    .imm5(imm5), .bsel(bsel), .asel(asel), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .Ain(Ain), .Bin(Bin), .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rn, rm;
    logic [1:0]  shift;
    logic [4:0]  imm5;
    logic        bsel, asel;
    logic [1:0]  op;
    logic        pw_en;  logic [2:0] pw_num; logic [15:0] pw_dat;
    logic        wa_en;  logic [2:0] wa_num; logic [15:0] wa_dat;
    logic        wb_en;  logic [2:0] wb_num; logic [15:0] wb_dat;
    int          stall;
    logic        sw_en;  logic [2:0] sw_num; logic [15:0] sw_dat;
    logic [15:0] exp_a, exp_b;
  } xact_t;

  xact_t       tbl [10];
  logic [15:0] m_regs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic xact_t base(input logic [2:0] a_rn, input logic [2:0] a_rm,
                                 input logic [1:0] a_sh, input logic [4:0] a_imm,
                                 input logic a_bsel, input logic a_asel, input logic [1:0] a_op,
                                 input logic [15:0] ea, input logic [15:0] eb);
    xact_t x;
    x.rn = a_rn; x.rm = a_rm; x.shift = a_sh; x.imm5 = a_imm;
    x.bsel = a_bsel; x.asel = a_asel; x.op = a_op;
    x.pw_en = 1'b0; x.pw_num = '0; x.pw_dat = '0;
    x.wa_en = 1'b0; x.wa_num = '0; x.wa_dat = '0;
    x.wb_en = 1'b0; x.wb_num = '0; x.wb_dat = '0;
    x.stall = 0;
    x.sw_en = 1'b0; x.sw_num = '0; x.sw_dat = '0;
    x.exp_a = ea; x.exp_b = eb;
    return x;
  endfunction

  // Reference arithmetic for the B path, expressed with integer math.
  function automatic logic [15:0] m_shift(input logic [15:0] v, input logic [1:0] sh);
    int unsigned u, r;
    u = 32'(v);
    case (sh)
      2'd1:    r = (u * 2) % 65536;
      2'd2:    r = u / 2;
      2'd3:    r = u / 2 + ((u >= 32768) ? 32768 : 0);
      default: r = u;
    endcase
    return 16'(r);
  endfunction

  function automatic logic [15:0] m_sext(input logic [4:0] imm);
    int unsigned u;
    u = 32'(imm);
    return (u >= 16) ? 16'(u + 65504) : 16'(u);
  endfunction

  // Applies the transaction's writes in edge order and returns the expected operands.
  function automatic xact_t model_run(input xact_t x);
    xact_t r;
    r = x;
    if (x.pw_en) m_regs[x.pw_num] = x.pw_dat;
    if (x.wa_en) m_regs[x.wa_num] = x.wa_dat;
    r.exp_a = x.asel ? 16'h0000 : m_regs[x.rn];
    if (x.wb_en) m_regs[x.wb_num] = x.wb_dat;
    r.exp_b = x.bsel ? m_sext(x.imm5) : m_shift(m_regs[x.rm], x.shift);
    if (x.sw_en) m_regs[x.sw_num] = x.sw_dat;
    return r;
  endfunction

  task automatic wr_reg(input logic [2:0] n, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_num = n; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_xact(input xact_t x, input string tag);
    int cnt;
    if (x.pw_en) wr_reg(x.pw_num, x.pw_dat);
    @(negedge clk);
    wr_en = 1'b0;
    rn = x.rn; rm = x.rm; shift = x.shift; imm5 = x.imm5;
    bsel = x.bsel; asel = x.asel; op = x.op; req_valid = 1'b1;
    chk({tag, " req_ready idle"}, 16'(req_ready), 16'h1);
    @(negedge clk);
    req_valid = 1'b0;
    rn = 3'($urandom); rm = 3'($urandom); shift = 2'($urandom); imm5 = 5'($urandom);
    bsel = 1'($urandom); asel = 1'($urandom); op = 2'($urandom);
    chk({tag, " req_ready rd_a"}, 16'(req_ready), 16'h0);
    chk({tag, " out_valid rd_a"}, 16'(out_valid), 16'h0);
    wr_en = x.wa_en; wr_num = x.wa_num; wr_data = x.wa_dat;
    @(negedge clk);
    wr_en = x.wb_en; wr_num = x.wb_num; wr_data = x.wb_dat;
    chk({tag, " out_valid rd_b"}, 16'(out_valid), 16'h0);
    @(negedge clk);
    wr_en = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " extra latency"}, 16'(cnt), 16'h0);
    chk({tag, " Ain"}, Ain, x.exp_a);
    chk({tag, " Bin"}, Bin, x.exp_b);
    chk({tag, " ALUop"}, 16'(ALUop), 16'(x.op));
    chk({tag, " req_ready out"}, 16'(req_ready), 16'h0);
    for (int s = 0; s < x.stall; s++) begin
      if (s == 0 && x.sw_en) begin
        wr_en = 1'b1; wr_num = x.sw_num; wr_data = x.sw_dat;
      end
      @(negedge clk);
      wr_en = 1'b0;
      chk({tag, " stall out_valid"}, 16'(out_valid), 16'h1);
      chk({tag, " stall req_ready"}, 16'(req_ready), 16'h0);
      chk({tag, " stall Ain"}, Ain, x.exp_a);
      chk({tag, " stall Bin"}, Bin, x.exp_b);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after xfer"}, 16'(out_valid), 16'h0);
    chk({tag, " req_ready after xfer"}, 16'(req_ready), 16'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    xact_t x;
    reset_n = 1'b0; wr_en = 1'b0; wr_num = '0; wr_data = '0;
    req_valid = 1'b0; rn = '0; rm = '0; shift = '0; imm5 = '0;
    bsel = 1'b0; asel = 1'b0; op = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;

    repeat (2) @(negedge clk);
    chk("reset out_valid", 16'(out_valid), 16'h0);
    chk("reset req_ready", 16'(req_ready), 16'h1);
    chk("reset Ain", Ain, 16'h0);
    chk("reset Bin", Bin, 16'h0);
    chk("reset ALUop", 16'(ALUop), 16'h0);
    reset_n = 1'b1;

    wr_reg(3'd3, 16'h1234); m_regs[3] = 16'h1234;
    wr_reg(3'd5, 16'h00F0); m_regs[5] = 16'h00F0;

    tbl[0] = base(3'd3, 3'd5, 2'b00, 5'h00, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h00F0);
    tbl[1] = base(3'd3, 3'd5, 2'b01, 5'h00, 1'b0, 1'b0, 2'b01, 16'h1234, 16'h0002);
    tbl[1].pw_en = 1'b1; tbl[1].pw_num = 3'd5; tbl[1].pw_dat = 16'h8001;
    tbl[2] = base(3'd3, 3'd5, 2'b10, 5'h00, 1'b0, 1'b0, 2'b10, 16'h1234, 16'h4000);
    tbl[3] = base(3'd3, 3'd5, 2'b11, 5'h00, 1'b0, 1'b0, 2'b11, 16'h1234, 16'hC000);
    tbl[4] = base(3'd3, 3'd5, 2'b01, 5'b10011, 1'b1, 1'b1, 2'b00, 16'h0000, 16'hFFF3);
    tbl[5] = base(3'd3, 3'd5, 2'b11, 5'b01111, 1'b1, 1'b0, 2'b10, 16'h1234, 16'h000F);
    tbl[6] = base(3'd3, 3'd5, 2'b00, 5'h00, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h8001);
    tbl[6].stall = 5; tbl[6].sw_en = 1'b1; tbl[6].sw_num = 3'd3; tbl[6].sw_dat = 16'hFFFF;
    tbl[7] = base(3'd2, 3'd3, 2'b00, 5'h00, 1'b0, 1'b0, 2'b11, 16'hBEEF, 16'hFFFF);
    tbl[7].wa_en = 1'b1; tbl[7].wa_num = 3'd2; tbl[7].wa_dat = 16'hBEEF;
    tbl[8] = base(3'd4, 3'd4, 2'b01, 5'h00, 1'b0, 1'b0, 2'b01, 16'h0000, 16'h26AE);
    tbl[8].wb_en = 1'b1; tbl[8].wb_num = 3'd4; tbl[8].wb_dat = 16'h1357;
    tbl[9] = base(3'd2, 3'd2, 2'b11, 5'h00, 1'b0, 1'b0, 2'b10, 16'hBEEF, 16'hDF77);
    tbl[9].stall = 2; tbl[9].sw_en = 1'b1; tbl[9].sw_num = 3'd2; tbl[9].sw_dat = 16'h0000;

    for (int i = 0; i < 10; i++) begin
      x = model_run(tbl[i]);
      run_xact(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset asserted while in RD_B, with a request held high during reset.
    @(negedge clk);
    rn = 3'd3; rm = 3'd5; shift = 2'b00; bsel = 1'b0; asel = 1'b0; op = 2'b01; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b1;
    #2;
    chk("abort out_valid", 16'(out_valid), 16'h0);
    chk("abort req_ready", 16'(req_ready), 16'h1);
    chk("abort Ain", Ain, 16'h0);
    chk("abort ALUop", 16'(ALUop), 16'h0);
    @(negedge clk);
    chk("in reset out_valid", 16'(out_valid), 16'h0);
    chk("in reset req_ready", 16'(req_ready), 16'h1);
    req_valid = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    x = model_run(base(3'd3, 3'd3, 2'b00, 5'h00, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0));
    run_xact(x, "post reset R3");

    for (int i = 0; i < 40; i++) begin
      x = base(3'($urandom), 3'($urandom), 2'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 2'($urandom), 16'h0, 16'h0);
      x.bsel = ($urandom_range(0, 3) == 0);
      x.asel = ($urandom_range(0, 3) == 0);
      x.pw_en = 1'($urandom); x.pw_num = 3'($urandom); x.pw_dat = 16'($urandom);
      x.wa_en = 1'($urandom); x.wa_num = 3'($urandom); x.wa_dat = 16'($urandom);
      x.wb_en = 1'($urandom); x.wb_num = 3'($urandom); x.wb_dat = 16'($urandom);
      x.stall = $urandom_range(0, 3);
      x.sw_en = (x.stall > 0) && 1'($urandom);
      x.sw_num = 3'($urandom); x.sw_dat = 16'($urandom);
      x = model_run(x);
      run_xact(x, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
